// File: rtl/xge_pkt_pkg.sv
// Shared definitions for the 64-bit packet TX path: lane positions, MOD width, FSM states.
package xge_pkt_pkg;

  localparam int MOD_W = 3;

  // MSB of each byte lane; lane 0 is the first byte on the wire.
  localparam int LANE0 = 63;
  localparam int LANE1 = 55;
  localparam int LANE2 = 47;
  localparam int LANE3 = 39;
  localparam int LANE4 = 31;
  localparam int LANE5 = 23;
  localparam int LANE6 = 15;
  localparam int LANE7 = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  function automatic int lane_msb(input int lane);
    return LANE0 - 8 * lane;
  endfunction

endpackage

// File: rtl/pkt_tx_buf.sv
// Packet byte buffer: byte-wide write port, combinational 8-byte word read by word index.
module pkt_tx_buf
  import xge_pkt_pkg::*;
#(
  parameter int BUF_DEPTH = 2048,
  parameter int AW        = 11
) (
  input  logic          clk_156m25,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-4:0] rd_idx,
  output logic [63:0]   rd_word
);

  logic [7:0] mem [BUF_DEPTH];

  always_ff @(posedge clk_156m25) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign rd_word[lane_msb(i) -: 8] = mem[{rd_idx, 3'(i)}];
  end

endmodule

// File: rtl/pkt_tx_source.sv
// Packet transmit source: sends buffer[0..len-1] as SOP/EOP/MOD framed 64-bit words,
// stalling on pkt_tx_full without losing or repeating words.
module pkt_tx_source
  import xge_pkt_pkg::*;
#(
  parameter int BUF_DEPTH = 2048,
  parameter int AW        = 11,
  parameter int LW        = 12
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             buf_wr_en,
  input  logic [AW-1:0]    buf_wr_addr,
  input  logic [7:0]       buf_wr_data,
  input  logic [LW-1:0]    tx_length,
  input  logic             tx_start,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [31:0]      tx_count,
  output logic [63:0]      pkt_tx_data,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [MOD_W-1:0] pkt_tx_mod,
  input  logic             pkt_tx_full
);

  localparam int WW = AW - 3;

  tx_state_e     state;
  logic [LW-1:0] len_q;
  logic [WW-1:0] widx;
  logic [63:0]   rd_word_p0;
  logic [63:0]   masked_p0;
  logic [LW-1:0] base_p0;
  logic          last_p0;
  logic          start_ok;
  logic          buf_we;

  assign buf_we   = buf_wr_en && (state == ST_IDLE);
  assign start_ok = tx_start && (tx_length != '0) && (tx_length <= LW'(BUF_DEPTH));

  pkt_tx_buf #(
    .BUF_DEPTH (BUF_DEPTH),
    .AW        (AW)
  ) u_buf (
    .clk_156m25 (clk_156m25),
    .wr_en      (buf_we),
    .wr_addr    (buf_wr_addr),
    .wr_data    (buf_wr_data),
    .rd_idx     (widx),
    .rd_word    (rd_word_p0)
  );

  // Stage p0: current word fetched, lanes past the packet end zeroed.
  assign base_p0 = LW'({widx, 3'b000});
  assign last_p0 = (base_p0 + LW'(8)) >= len_q;

  always_comb begin
    masked_p0 = '0;
    for (int i = 0; i < 8; i++) begin
      if ((base_p0 + LW'(i)) < len_q)
        masked_p0[lane_msb(i) -: 8] = rd_word_p0[lane_msb(i) -: 8];
    end
  end

  // Stage p1: registered framing outputs and control.
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      widx        <= '0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_count    <= '0;
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
    end else begin
      tx_done     <= 1'b0;
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state   <= ST_SEND;
            tx_busy <= 1'b1;
            len_q   <= tx_length;
            widx    <= '0;
          end
        end
        ST_SEND: begin
          // The EOP word is already on the bus this cycle, so the packet is complete.
          if (pkt_tx_val && pkt_tx_eop) begin
            state    <= ST_IDLE;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            tx_count <= tx_count + 32'd1;
          end else if (!pkt_tx_full) begin
            pkt_tx_data <= masked_p0;
            pkt_tx_val  <= 1'b1;
            pkt_tx_sop  <= (widx == '0);
            pkt_tx_eop  <= last_p0;
            pkt_tx_mod  <= last_p0 ? len_q[MOD_W-1:0] : '0;
            if (!last_p0) widx <= widx + WW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_source.sv
// Directed bench for pkt_tx_source: framing, lane masking, back-pressure, reset and ignored starts.
`timescale 1ns/100ps
module tb_pkt_tx_source;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25_n = 1'b0;
  logic        buf_wr_en = 1'b0;
  logic [10:0] buf_wr_addr = '0;
  logic [7:0]  buf_wr_data = '0;
  logic [11:0] tx_length = '0;
  logic        tx_start = 1'b0;
  logic        tx_busy, tx_done;
  logic [31:0] tx_count;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        pkt_tx_full = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mem_m [64];
  logic [63:0] q_data [$];
  bit          q_sop [$];
  bit          q_eop [$];
  logic [2:0]  q_mod [$];
  int          q_cyc [$];
  int          cyc = 0;
  int          done_cnt = 0;

  always #5 clk_156m25 = ~clk_156m25;

  pkt_tx_source dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .buf_wr_en      (buf_wr_en),
    .buf_wr_addr    (buf_wr_addr),
    .buf_wr_data    (buf_wr_data),
    .tx_length      (tx_length),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_count       (tx_count),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_full    (pkt_tx_full)
  );

  // Word monitor: samples 1 ns after each edge; the stimulus side looks at 2 ns.
  always @(posedge clk_156m25) begin
    #1;
    cyc++;
    if (pkt_tx_val) begin
      q_data.push_back(pkt_tx_data);
      q_sop.push_back(pkt_tx_sop);
      q_eop.push_back(pkt_tx_eop);
      q_mod.push_back(pkt_tx_mod);
      q_cyc.push_back(cyc);
    end
    if (tx_done) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_156m25);
    #2;
  endtask

  task automatic clear_q();
    q_data.delete(); q_sop.delete(); q_eop.delete(); q_mod.delete(); q_cyc.delete();
  endtask

  function automatic logic [63:0] exp_word(input int k, input int len);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (8 * k + i < len) w[63 - 8 * i -: 8] = mem_m[8 * k + i];
    return w;
  endfunction

  task automatic write_byte(input int addr, input logic [7:0] data);
    buf_wr_en = 1'b1; buf_wr_addr = 11'(addr); buf_wr_data = data;
    tick();
    buf_wr_en = 1'b0;
  endtask

  task automatic start_pkt(input int len, output int s_cyc);
    clear_q();
    tx_length = 12'(len);
    tx_start  = 1'b1;
    tick();
    tx_start  = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_words(input string tag, input int n);
    int c = 0;
    while (q_data.size() < n && c < 100) begin tick(); c++; end
    check_val({tag, "_words_seen"}, 64'(q_data.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!tx_done && c < 300) begin tick(); c++; end
    check_val({tag, "_done"}, 64'(tx_done), 64'd1);
    check_val({tag, "_busy_at_done"}, 64'(tx_busy), 64'd0);
  endtask

  task automatic check_pkt(input string tag, input int len);
    int nw = (len + 7) / 8;
    check_val({tag, "_nwords"}, 64'(q_data.size()), 64'(nw));
    for (int k = 0; k < nw && k < q_data.size(); k++) begin
      check_val($sformatf("%s_w%0d_data", tag, k), q_data[k], exp_word(k, len));
      check_val($sformatf("%s_w%0d_sop", tag, k), 64'(q_sop[k]), 64'(k == 0));
      check_val($sformatf("%s_w%0d_eop", tag, k), 64'(q_eop[k]), 64'(k == nw - 1));
      check_val($sformatf("%s_w%0d_mod", tag, k), 64'(q_mod[k]), 64'((k == nw - 1) ? len % 8 : 0));
    end
  endtask

  initial begin
    int s;
    int n;

    tick(); tick();
    check_val("rst_val", 64'(pkt_tx_val), 64'd0);
    check_val("rst_sop_eop_mod", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 64'd0);
    check_val("rst_data", pkt_tx_data, 64'd0);
    check_val("rst_busy_done", {tx_busy, tx_done}, 64'd0);
    check_val("rst_count", 64'(tx_count), 64'd0);
    reset_156m25_n = 1'b1;
    tick();

    for (int i = 0; i < 64; i++) begin
      mem_m[i] = 8'(i);
      write_byte(i, 8'(i));
    end

    // Reset in the middle of a packet, after word 3.
    start_pkt(64, s);
    wait_words("A", 4);
    reset_156m25_n = 1'b0;
    tick();
    check_val("A_rst_val", 64'(pkt_tx_val), 64'd0);
    check_val("A_rst_sop_eop", {pkt_tx_sop, pkt_tx_eop}, 64'd0);
    check_val("A_rst_data", pkt_tx_data, 64'd0);
    check_val("A_rst_busy", 64'(tx_busy), 64'd0);
    check_val("A_rst_count", 64'(tx_count), 64'd0);
    reset_156m25_n = 1'b1;
    repeat (6) tick();
    check_val("A_no_words_after_rst", 64'(q_data.size()), 64'd4);
    check_val("A_no_done", 64'(done_cnt), 64'd0);

    // Full 64-byte packet.
    start_pkt(64, s);
    check_val("B_no_word_at_start", 64'(pkt_tx_val), 64'd0);
    check_val("B_busy", 64'(tx_busy), 64'd1);
    wait_done("B");
    check_val("B_count", 64'(tx_count), 64'd1);
    check_pkt("B", 64);
    if (q_data.size() == 8) begin
      check_val("B_w0_const", q_data[0], 64'h0001020304050607);
      check_val("B_w7_const", q_data[7], 64'h38393A3B3C3D3E3F);
      check_val("B_first_latency", 64'(q_cyc[0]), 64'(s + 1));
      check_val("B_done_after_eop", 64'(cyc), 64'(q_cyc[7] + 1));
    end
    tick();
    check_val("B_done_pulse", 64'(tx_done), 64'd0);

    // 60 bytes: partial last word.
    start_pkt(60, s);
    wait_done("C");
    check_val("C_count", 64'(tx_count), 64'd2);
    check_pkt("C", 60);
    if (q_data.size() == 8) check_val("C_last_const", q_data[7], 64'h38393A3B00000000);
    tick();
    check_val("C_done_pulse", 64'(tx_done), 64'd0);

    // Back-pressure for three edges after word 2.
    start_pkt(64, s);
    wait_words("D", 3);
    pkt_tx_full = 1'b1;
    repeat (3) tick();
    pkt_tx_full = 1'b0;
    wait_done("D");
    check_val("D_count", 64'(tx_count), 64'd3);
    check_pkt("D", 64);
    if (q_data.size() == 8) begin
      check_val("D_w3_const", q_data[3], 64'h18191A1B1C1D1E1F);
      check_val("D_gap_w1_w2", 64'(q_cyc[2] - q_cyc[1]), 64'd1);
      check_val("D_gap_w2_w3", 64'(q_cyc[3] - q_cyc[2]), 64'd4);
    end

    // Zero length start is ignored.
    start_pkt(0, s);
    check_val("E_len0_busy", 64'(tx_busy), 64'd0);
    repeat (4) tick();
    check_val("E_len0_words", 64'(q_data.size()), 64'd0);

    // Start, length change and buffer write while busy are all ignored.
    n = done_cnt;
    start_pkt(64, s);
    wait_words("E", 2);
    tx_start = 1'b1; tx_length = 12'd8;
    buf_wr_en = 1'b1; buf_wr_addr = 11'd1; buf_wr_data = 8'hEE;
    tick();
    tx_start = 1'b0; buf_wr_en = 1'b0;
    wait_done("E");
    check_val("E_count", 64'(tx_count), 64'd4);
    check_pkt("E", 64);
    repeat (6) tick();
    check_val("E_one_packet", 64'(done_cnt - n), 64'd1);
    check_val("E_no_extra_words", 64'(q_data.size()), 64'd8);

    // Single-byte packet.
    write_byte(0, 8'hAA);
    mem_m[0] = 8'hAA;
    start_pkt(1, s);
    wait_done("F");
    check_pkt("F", 1);
    if (q_data.size() == 1) check_val("F_const", q_data[0], 64'hAA00000000000000);
    check_val("F_count", 64'(tx_count), 64'd5);

    // Two bytes: byte 1 must still hold its pre-busy value.
    start_pkt(2, s);
    wait_done("G");
    check_pkt("G", 2);
    if (q_data.size() == 1) check_val("G_const", q_data[0], 64'hAA01000000000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
